// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 7-segment scan slice.
//   seg_t   : one active-low segment pattern (g..a)
//   frame_t : four patterns; index 0 = seg1, 1 = seg2, 2 = result, 3 = flags
//   state_t : scan FSM states
package seg_disp_pkg;

    typedef logic [6:0] seg_t;
    typedef seg_t [3:0] frame_t;

    localparam int   N_DIGITS = 4;
    localparam seg_t SEG_OFF  = 7'h7F;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

endpackage

// File: rtl/seg_frame_buffer.sv
// One-entry valid/ready frame buffer feeding the display scanner.
// A frame is captured into pending on a handshake and promoted to active
// only on a frame boundary, so the displayed frame never changes mid-scan.
// Ports:
//   clk_i, reset_ni  : clock, asynchronous active-low reset
//   boundary_i       : last drive cycle of digit 3
//   frame_valid_i    : producer offers frame_i
//   frame_i          : four patterns to capture
//   frame_ready_o    : buffer can accept a frame this cycle
//   active_o         : frame currently being displayed
module seg_frame_buffer
    import seg_disp_pkg::*;
(
    input  logic   clk_i,
    input  logic   reset_ni,
    input  logic   boundary_i,
    input  logic   frame_valid_i,
    input  frame_t frame_i,
    output logic   frame_ready_o,
    output frame_t active_o
);

    logic   pend_full_q, pend_full_d;
    frame_t pend_q, pend_d;
    frame_t active_q, active_d;
    logic   xfer;

    // A boundary frees the pending slot in the same cycle, so a full buffer
    // can still accept while its old contents move to active.
    assign frame_ready_o = !pend_full_q || boundary_i;
    assign xfer          = frame_valid_i && frame_ready_o;
    assign active_o      = active_q;

    always_comb begin
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        active_d    = active_q;
        if (boundary_i && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = frame_i;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pend_full_q <= 1'b0;
            pend_q      <= {N_DIGITS{SEG_OFF}};
            active_q    <= {N_DIGITS{SEG_OFF}};
        end else begin
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for four 7-segment digits sharing one segment bus.
// Each digit gets BLANK_CYCLES of all-off followed by DWELL_CYCLES of drive,
// in the order seg1, seg2, result_seg, flags_seg.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   dim             : brightness 0..7 (only with SEG_DIM_EN defined)
//   frame_valid     : new frame presented on seg1/seg2/result_seg/flags_seg
//   frame_ready     : frame can be accepted this cycle
//   seg1..flags_seg : active-low patterns for digits 0..3
//   seg_out         : shared active-low segment bus (registered)
//   dig_en_n        : active-low one-hot digit enables (registered)
//   frame_tick      : pulse on the last drive cycle of digit 3
// Optional feature macro: SEG_DIM_EN (adds dim input and PWM within dwell).
module seg_display_scanner
    import seg_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SEG_DIM_EN
    input  logic [2:0] dim,
`endif
    input  logic       frame_valid,
    output logic       frame_ready,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] result_seg,
    input  logic [6:0] flags_seg,
    output logic [6:0] seg_out,
    output logic [3:0] dig_en_n,
    output logic       frame_tick
);

    localparam int DCW = $clog2(DWELL_CYCLES);
    localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYCLES - 1);
    localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_CYCLES - 1);

    if (DWELL_CYCLES < 2) begin : g_dwell_chk
        $error("DWELL_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_blank_chk
        $error("BLANK_CYCLES must be at least 1");
    end
`ifdef SEG_DIM_EN
    if ((DWELL_CYCLES % 8) != 0) begin : g_dim_chk
        $error("DWELL_CYCLES must be a multiple of 8 when dimming is enabled");
    end
`endif

    state_t         state_q, state_d;
    logic [1:0]     digit_q, digit_d;
    logic [DCW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BCW-1:0] blank_cnt_q, blank_cnt_d;
    logic [6:0]     seg_q, seg_d;
    logic [3:0]     en_q, en_d;
    logic           tick_q, tick_d;
    frame_t         frame_in;
    frame_t         active;
`ifdef SEG_DIM_EN
    logic [31:0]    dim_lhs, dim_rhs;
`endif

    assign frame_in = {flags_seg, result_seg, seg2, seg1};

    // tick_q is high exactly on the boundary cycle, so it doubles as the
    // buffer's promote strobe without any extra decode.
    seg_frame_buffer u_buf (
        .clk_i         (clk),
        .reset_ni      (reset),
        .boundary_i    (tick_q),
        .frame_valid_i (frame_valid),
        .frame_i       (frame_in),
        .frame_ready_o (frame_ready),
        .active_o      (active)
    );

    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        case (state_q)
            ST_BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = ST_DRIVE;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BCW'(1);
                end
            end
            ST_DRIVE: begin
                if (dwell_cnt_q == DWELL_LAST) begin
                    state_d     = ST_BLANK;
                    dwell_cnt_d = '0;
                    digit_d     = digit_q + 2'd1;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DCW'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Outputs are decoded from next-state and registered so they line up
    // with the state register. Active only changes on the boundary edge,
    // which is always followed by a blank phase, so reading it here is safe.
    always_comb begin
        seg_d  = SEG_OFF;
        en_d   = '1;
        tick_d = 1'b0;
`ifdef SEG_DIM_EN
        dim_lhs = 32'(dwell_cnt_d) * 32'd8;
        dim_rhs = (32'(dim) + 32'd1) * 32'(DWELL_CYCLES);
`endif
        if (state_d == ST_DRIVE) begin
            en_d   = ~(4'b0001 << digit_d);
            seg_d  = active[digit_d];
            tick_d = (digit_d == 2'd3) && (dwell_cnt_d == DWELL_LAST);
`ifdef SEG_DIM_EN
            if (dim_lhs >= dim_rhs) begin
                seg_d = SEG_OFF;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BLANK;
            digit_q     <= '0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
            seg_q       <= SEG_OFF;
            en_q        <= '1;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
            tick_q      <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_en_n   = en_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner with DWELL=8, BLANK=2.
module tb_seg_display_scanner;

    localparam int DW     = 8;
    localparam int BW     = 2;
    localparam int SLOT   = DW + BW;
    localparam int PERIOD = 4 * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_valid = 1'b0;
    logic       frame_ready;
    logic [6:0] seg1 = '0, seg2 = '0, result_seg = '0, flags_seg = '0;
    logic [6:0] seg_out;
    logic [3:0] dig_en_n;
    logic       frame_tick;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef SEG_DIM_EN
        .dim         (3'd7),
`endif
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .seg1        (seg1),
        .seg2        (seg2),
        .result_seg  (result_seg),
        .flags_seg   (flags_seg),
        .seg_out     (seg_out),
        .dig_en_n    (dig_en_n),
        .frame_tick  (frame_tick)
    );

    int n_pass  = 0;
    int n_total = 0;
    int t       = 0;   // cycles since reset release

    // Reference model: displayed frame plus a one-deep queue of accepted frames.
    logic [6:0]  m_act [4];
    logic [27:0] m_pend [$];
    logic        last_xfer;

    typedef struct {
        int         t;
        logic [3:0] en;
        logic [6:0] seg;
        logic       tick;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    endtask

    function automatic logic [6:0] dig(input logic [27:0] f, input int k);
        return f[7*k +: 7];
    endfunction

    // One clock cycle: compare DUT against model, present stimulus, advance.
    task automatic cycle(input logic v, input logic [27:0] f);
        int         p;
        int         k;
        int         w;
        logic       tick;
        logic       ready;
        logic [3:0] one;
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        logic [27:0] f0;
        p     = t % PERIOD;
        k     = p / SLOT;
        w     = p % SLOT;
        one   = 4'b0001;
        tick  = (p == PERIOD - 1);
        ready = (m_pend.size() == 0) || tick;
        exp_en  = (w < BW) ? 4'hF : ~(one << k);
        exp_seg = (w < BW) ? 7'h7F : m_act[k];
        chk("seg_out", seg_out, exp_seg);
        chk("dig_en_n", dig_en_n, exp_en);
        chk("frame_tick", frame_tick, tick);
        chk("frame_ready", frame_ready, ready);
        frame_valid = v;
        {flags_seg, result_seg, seg2, seg1} = f;
        last_xfer = v && ready;
        if (tick && m_pend.size() > 0) begin
            f0 = m_pend.pop_front();
            for (int j = 0; j < 4; j++) m_act[j] = dig(f0, j);
        end
        if (last_xfer) m_pend.push_back(f);
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        logic [31:0] r;
        while (t < target) begin
            r = $urandom;
            cycle(1'b0, r[27:0]);   // data must be ignored without valid
        end
    endtask

    // Called just after a negedge (or mid-cycle for the async case).
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_seg_out", seg_out, 7'h7F);
        chk("rst_dig_en_n", dig_en_n, 4'hF);
        chk("rst_frame_ready", frame_ready, 1'b1);
        chk("rst_frame_tick", frame_tick, 1'b0);
        frame_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 4; j++) m_act[j] = 7'h7F;
        m_pend.delete();
        t = 0;
    endtask

    task automatic offer_until_accepted(input string name, input logic [27:0] f, output int acc_t);
        logic acc;
        acc   = 1'b0;
        acc_t = -1;
        for (int i = 0; i < 3 * PERIOD && !acc; i++) begin
            cycle(1'b1, f);
            acc = last_xfer;
            if (acc) acc_t = t - 1;
        end
        frame_valid = 1'b0;
        chk({name, "_accept_timeout"}, acc, 1'b1);
    endtask

    initial begin
        vec_t        idle_tbl [11];
        vec_t        show_tbl [6];
        logic [27:0] fa, fb, fc, fd, off;
        logic [31:0] r;
        logic        offering;
        int          acc_t;

        idle_tbl[0]  = '{0,   4'hF, 7'h7F, 1'b0};
        idle_tbl[1]  = '{1,   4'hF, 7'h7F, 1'b0};
        idle_tbl[2]  = '{2,   4'hE, 7'h7F, 1'b0};
        idle_tbl[3]  = '{9,   4'hE, 7'h7F, 1'b0};
        idle_tbl[4]  = '{10,  4'hF, 7'h7F, 1'b0};
        idle_tbl[5]  = '{12,  4'hD, 7'h7F, 1'b0};
        idle_tbl[6]  = '{22,  4'hB, 7'h7F, 1'b0};
        idle_tbl[7]  = '{32,  4'h7, 7'h7F, 1'b0};
        idle_tbl[8]  = '{39,  4'h7, 7'h7F, 1'b1};
        idle_tbl[9]  = '{40,  4'hF, 7'h7F, 1'b0};
        idle_tbl[10] = '{79,  4'h7, 7'h7F, 1'b1};

        // Frame {40,79,24,30} accepted at t=100; visible from t=120.
        show_tbl[0] = '{115, 4'h7, 7'h7F, 1'b0};
        show_tbl[1] = '{119, 4'h7, 7'h7F, 1'b1};
        show_tbl[2] = '{125, 4'hE, 7'h40, 1'b0};
        show_tbl[3] = '{135, 4'hD, 7'h79, 1'b0};
        show_tbl[4] = '{145, 4'hB, 7'h24, 1'b0};
        show_tbl[5] = '{155, 4'h7, 7'h30, 1'b0};

        @(negedge clk);
        do_reset();

        // Idle scan: blank segments, digit enables rotate, tick every period.
        for (int i = 0; i < 11; i++) begin
            run_to(idle_tbl[i].t);
            chk("idle_en", dig_en_n, idle_tbl[i].en);
            chk("idle_seg", seg_out, idle_tbl[i].seg);
            chk("idle_tick", frame_tick, idle_tbl[i].tick);
        end
        run_to(100);

        // Mid-frame accept: held back until the boundary.
        cycle(1'b1, {7'h30, 7'h24, 7'h79, 7'h40});
        frame_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_to(show_tbl[i].t);
            chk("show_en", dig_en_n, show_tbl[i].en);
            chk("show_seg", seg_out, show_tbl[i].seg);
            chk("show_tick", frame_tick, show_tbl[i].tick);
        end

        // Back-to-back A then B: B waits for the boundary at t=199.
        r = $urandom; fa = r[27:0];
        r = $urandom; fb = r[27:0] ^ 28'h5A5A5A5;
        run_to(165);
        offer_until_accepted("A", fa, acc_t);
        chk("A_accept_cycle", acc_t, 165);
        chk("B_blocked_ready", frame_ready, 1'b0);
        offer_until_accepted("B", fb, acc_t);
        chk("B_accept_cycle", acc_t, 199);
        run_to(205);
        chk("A_shown", seg_out, dig(fa, 0));
        run_to(245);
        chk("B_shown", seg_out, dig(fb, 0));

        // Offer exactly on the boundary with pending empty.
        r = $urandom; fc = r[27:0] ^ 28'h0F0F0F0;
        run_to(279);
        chk("ready_on_boundary", frame_ready, 1'b1);
        cycle(1'b1, fc);
        frame_valid = 1'b0;
        run_to(285);
        chk("B_still_shown", seg_out, dig(fb, 0));
        run_to(325);
        chk("C_shown", seg_out, dig(fc, 0));

        // Reset mid digit-2 drive with a pending frame.
        r = $urandom; fd = r[27:0];
        run_to(330);
        cycle(1'b1, fd);
        frame_valid = 1'b0;
        run_to(345);
        chk("pre_rst_en", dig_en_n, 4'hB);
        #2;
        do_reset();
        run_to(5);
        chk("post_rst_en", dig_en_n, 4'hE);
        chk("post_rst_seg", seg_out, 7'h7F);
        run_to(50);

        // Random producer that holds its frame until accepted.
        offering = 1'b0;
        off      = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!offering && $urandom_range(0, 5) == 0) begin
                offering = 1'b1;
                r   = $urandom;
                off = r[27:0];
            end
            if (offering) cycle(1'b1, off);
            else begin
                r = $urandom;
                cycle(1'b0, r[27:0]);
            end
            if (last_xfer) offering = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0d: bench did not finish", t);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Consumer end of the registered 7-segment pattern stage: takes the four registered patterns (operand 1, operand 2, result, flags) and drives one shared segment bus plus four active-low digit enables, time-multiplexed.
- A one-entry valid/ready frame buffer decouples pattern updates from the scan.
- Active patterns change only at frame boundaries, so a digit never shows a mixed frame.

Parameters:
- DWELL_CYCLES, 50000, clk cycles each digit is driven (min 2).
- BLANK_CYCLES, 500, clk cycles all digits are off before each digit (anti-ghosting; min 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_valid  in  1  a new frame is presented on seg1/seg2/result_seg/flags_seg.
- frame_ready  out  1  block can accept a frame this cycle.
- seg1  in  7  digit 0 pattern, active-low segments (g..a).
- seg2  in  7  digit 1 pattern.
- result_seg  in  7  digit 2 pattern.
- flags_seg  in  7  digit 3 pattern.
- seg_out  out  7  shared segment bus, active-low.
- dig_en_n  out  4  digit enables, active-low, one-hot-low.
- frame_tick  out  1  one-cycle pulse on the frame-boundary cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: seg_out=7'h7F, dig_en_n=4'hF, frame_ready=1, frame_tick=0.
  - Internal state: active frame all 7'h7F, pending empty, digit_idx=0, state=ST_BLANK, counters 0.
- Release from reset takes effect on the first clk edge with reset=1.
- FSM, two states:
  - ST_BLANK: lasts BLANK_CYCLES. dig_en_n=4'hF, seg_out=7'h7F. Then go to ST_DRIVE.
  - ST_DRIVE: lasts DWELL_CYCLES. dig_en_n=~(4'b1<<digit_idx), seg_out=active[digit_idx]. Then go to ST_BLANK with digit_idx=(digit_idx+1) mod 4, wrapping 3->0.
- Frame timing:
  - Frame period is 4*(BLANK_CYCLES+DWELL_CYCLES) cycles.
  - Digit order is seg1, seg2, result_seg, flags_seg.
- seg_out and dig_en_n come straight from flops, with no combinational path from any input. They are computed from next-state so they match the current state in the same cycle.
- Frame boundary: the last ST_DRIVE cycle of digit 3. frame_tick=1 in that cycle only.
- Handshake:
  - frame_ready = !pending_full || boundary.
  - A transfer happens when frame_valid && frame_ready. All four inputs are captured into pending at that edge.
  - Inputs are ignored when no transfer occurs.
  - The producer holds its data while valid && !ready.
- Pending-to-active: at a boundary edge with pending full, pending is copied to active and pending clears.
  - If a transfer happens in the same cycle, the old pending moves to active and the new frame fills pending. Pending stays full.
- Latency: a frame accepted outside a boundary first appears at the next digit-0 ST_DRIVE, at most one frame period plus BLANK_CYCLES later.
- Pending full with no boundary: frame_ready=0. There is no overwrite and no loss.
- Without any accepted frame, the display stays blank (7'h7F) indefinitely.
- Reset mid-scan: the scan is abandoned immediately, outputs go to their reset values, and pending is discarded.
- Counter widths are $clog2 of their parameter. Counters compare against the parameter minus 1.

Optional Feature:
- Macro: SEG_DIM_EN.
- Defined:
  - Adds input port dim (3 bits).
  - In ST_DRIVE, seg_out=active[digit_idx] only while dwell_cnt*8 < (dim+1)*DWELL_CYCLES; otherwise seg_out=7'h7F.
  - dig_en_n timing is unchanged.
  - dim=7 gives full brightness.
  - DWELL_CYCLES must be a multiple of 8; this is checked with an elaboration assertion.
- Undefined: no dim port; segments are driven for the full dwell.

Decomposition:
- Package seg_disp_pkg holds:
  - typedef seg_t (logic [6:0]).
  - typedef frame_t (seg_t [3:0]).
  - localparam N_DIGITS=4.
  - localparam SEG_OFF=7'h7F.
  - enum state_t {ST_BLANK, ST_DRIVE}.
- Sub-module seg_frame_buffer holds the pending and active registers, the valid/ready logic and the boundary transfer. Its inputs are boundary and the frame; its outputs are frame_ready and the active frame.
- The top level holds the FSM, counters, output flops and the dimming logic.

Test Plan (all cases use DWELL_CYCLES=8, BLANK_CYCLES=2, so the frame period is 40):
- Reset then idle 100 cycles -> seg_out=7'h7F throughout. dig_en_n cycles 4'hE/D/B/7 for 8 cycles each, separated by 2 cycles of 4'hF. frame_tick every 40 cycles.
- Accept frame {40,79,24,30} (hex) mid-frame -> old (blank) patterns are kept until the boundary. The next frame shows 7'h40 with dig_en_n=4'hE, 7'h79 with 4'hD, 7'h24 with 4'hB, 7'h30 with 4'h7.
- Two back-to-back frames A then B before a boundary -> A is accepted. frame_ready=0 while B is held. B is accepted on the boundary cycle as A moves to active. The next frame shows A, the frame after shows B.
- frame_valid asserted exactly on the boundary cycle with pending empty -> frame accepted, shown starting one frame later. No pattern changes mid-frame.
- Assert reset during digit 2 ST_DRIVE with pending full -> outputs are 7'h7F/4'hF immediately. After release the scan restarts at digit 0 and stays blank, because pending was discarded.
- SEG_DIM_EN defined, dim=1 -> during each 8-cycle dwell the pattern is driven for 2 cycles and 7'h7F for 6. dim=7 gives all 8 cycles.
